type_rule_cfg_ctrl: RTL and testbench



---
 rtl/parser_pkg.sv | 35 +++
 rtl/cfg_word_packer.sv | 59 +++++
 rtl/type_rule_cfg_ctrl.sv | 170 +++++++++++++++++
 tb/tb_type_rule_cfg_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared parser types: the type-lookup rule layout and the host config
// command encoding used by the rule-table configuration sequencer.
package parser_pkg;

  localparam int PARSER_RULE_NUM = 8;
  localparam int CFG_WORD_W      = 32;

  typedef struct packed {
    logic        typeRule_valid;
    logic [15:0] type_data;
    logic [15:0] type_mask;
    logic [7:0]  key_offset;
    logic [7:0]  next_hdr;
  } type_rule_t;

  localparam int RULE_WORDS = ($bits(type_rule_t) + CFG_WORD_W - 1) / CFG_WORD_W;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_CLEAR_ONE = 2'b01,
    OP_CLEAR_ALL = 2'b10,
    OP_RSVD      = 2'b11
  } cfg_op_e;

  localparam int HDR_OP_MSB    = 31;
  localparam int HDR_OP_LSB    = 30;
  localparam int HDR_STAGE_MSB = 29;
  localparam int HDR_STAGE_LSB = 24;
  localparam int HDR_RULE_MSB  = 23;
  localparam int HDR_RULE_LSB  = 16;

  localparam int HDR_STAGE_W = HDR_STAGE_MSB - HDR_STAGE_LSB + 1;
  localparam int HDR_RULE_W  = HDR_RULE_MSB - HDR_RULE_LSB + 1;

endpackage

// File: rtl/cfg_word_packer.sv
// Word-serial assembler: shifts payload words in LSB-word-first and flags the
// beat that completes a full record. o_data already includes the current word.
module cfg_word_packer #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 2,
  parameter int OUT_W  = WORD_W * WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_word,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_done
);

  localparam int TOT_W = WORD_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             last;
  logic [TOT_W-1:0] asm_nxt;

  assign last   = (cnt_q == CNT_W'(WORDS - 1));
  assign o_done = i_shift & last;

  generate
    if (WORDS > 1) begin : g_multi
      // Only the words received so far need storage; the final word is
      // taken straight from the bus on the completing beat.
      logic [TOT_W-WORD_W-1:0] hist_q;

      assign asm_nxt = {i_word, hist_q};

      // NOTE: hist_q is pure datapath and is only read on a beat qualified by
      // the reset counter, so it is deliberately left without a reset.
      always_ff @(posedge i_clk) begin
        if (i_shift) hist_q <= asm_nxt[TOT_W-1:WORD_W];
      end
    end else begin : g_single
      assign asm_nxt = i_word;
    end
  endgenerate

  assign o_data = asm_nxt[OUT_W-1:0];

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_start) begin
      cnt_q <= '0;
    end else if (i_shift) begin
      cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/type_rule_cfg_ctrl.sv
// Host-config sequencer for the per-stage type-lookup tables: decodes headers,
// assembles rules from payload words and commits them with a one-hot wren.
module type_rule_cfg_ctrl
  import parser_pkg::*;
#(
  parameter int STAGE_NUM  = 4,
  parameter int RULE_NUM   = PARSER_RULE_NUM,
  parameter int RULE_WORDS = parser_pkg::RULE_WORDS
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_cfg_valid,
  output logic                               o_cfg_ready,
  input  logic [CFG_WORD_W-1:0]              i_cfg_data,
  output logic [STAGE_NUM-1:0][RULE_NUM-1:0] o_rule_wren,
  output type_rule_t                         o_type_rule,
  output logic                               o_busy,
  output logic                               o_cfg_err,
  output logic [15:0]                        o_wr_cnt
);

  localparam int RULE_W = $bits(type_rule_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic                               accept;
  cfg_op_e                            hdr_op;
  logic [HDR_STAGE_W-1:0]             hdr_stage;
  logic [HDR_RULE_W-1:0]              hdr_rule;
  logic                               hdr_ok;
  logic [HDR_STAGE_W-1:0]             stage_q;
  logic [HDR_RULE_W-1:0]              rid_q;
  logic                               ok_q;
  logic [HDR_STAGE_W-1:0]             sel_stage;
  logic [HDR_RULE_W-1:0]              sel_rule;
  logic [STAGE_NUM-1:0][RULE_NUM-1:0] onehot;
  logic [RULE_W-1:0]                  pk_data;
  logic                               pk_done;

  logic [STAGE_NUM-1:0][RULE_NUM-1:0] wren_d;
  type_rule_t                         rule_d;
  logic                               err_d;
  logic                               ready_d;
  logic                               busy_d;
  logic [15:0]                        cnt_d;

  assign accept    = i_cfg_valid & o_cfg_ready;
  assign hdr_op    = cfg_op_e'(i_cfg_data[HDR_OP_MSB:HDR_OP_LSB]);
  assign hdr_stage = i_cfg_data[HDR_STAGE_MSB:HDR_STAGE_LSB];
  assign hdr_rule  = i_cfg_data[HDR_RULE_MSB:HDR_RULE_LSB];
  assign hdr_ok    = (int'(hdr_stage) < STAGE_NUM) && (int'(hdr_rule) < RULE_NUM);

  // Clears decode their target from the live header; writes from the latched one.
  assign sel_stage = (state_q == ST_IDLE) ? hdr_stage : stage_q;
  assign sel_rule  = (state_q == ST_IDLE) ? hdr_rule  : rid_q;

  always_comb begin
    onehot = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        onehot[s][r] = (int'(sel_stage) == s) && (int'(sel_rule) == r);
      end
    end
  end

  cfg_word_packer #(
    .WORD_W (CFG_WORD_W),
    .WORDS  (RULE_WORDS),
    .OUT_W  (RULE_W)
  ) u_packer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (accept && (state_q == ST_IDLE)),
    .i_shift (accept && (state_q == ST_LOAD)),
    .i_word  (i_cfg_data),
    .o_data  (pk_data),
    .o_done  (pk_done)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wren_d  = '0;
    rule_d  = o_type_rule;
    err_d   = 1'b0;
    cnt_d   = o_wr_cnt;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (hdr_op)
            OP_WRITE: state_d = ST_LOAD;
            OP_CLEAR_ONE: begin
              state_d = ST_COMMIT;
              if (hdr_ok) begin
                wren_d = onehot;
                rule_d = '0;
                cnt_d  = o_wr_cnt + 16'd1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLEAR_ALL: begin
              state_d = ST_COMMIT;
              wren_d  = '1;
              rule_d  = '0;
              cnt_d   = o_wr_cnt + 16'd1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        if (pk_done) begin
          if (ok_q) begin
            state_d = ST_COMMIT;
            wren_d  = onehot;
            rule_d  = type_rule_t'(pk_data);
            cnt_d   = o_wr_cnt + 16'd1;
          end else begin
            state_d = ST_DRAIN;
            err_d   = 1'b1;
          end
        end
      end
      ST_COMMIT, ST_DRAIN: state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      o_cfg_ready <= 1'b1;
      o_rule_wren <= '0;
      o_type_rule <= '0;
      o_busy      <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_wr_cnt    <= '0;
      stage_q     <= '0;
      rid_q       <= '0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_cfg_ready <= ready_d;
      o_rule_wren <= wren_d;
      o_type_rule <= rule_d;
      o_busy      <= busy_d;
      o_cfg_err   <= err_d;
      o_wr_cnt    <= cnt_d;
      if (accept && (state_q == ST_IDLE)) begin
        stage_q <= hdr_stage;
        rid_q   <= hdr_rule;
        ok_q    <= hdr_ok;
      end
    end
  end

endmodule

// File: tb/tb_type_rule_cfg_ctrl.sv
// Scoreboard bench for type_rule_cfg_ctrl: the stimulus pushes hand-computed
// commit/error events, a negedge monitor pops and compares them.
module tb_type_rule_cfg_ctrl;
  import parser_pkg::*;

  localparam int STAGE_NUM = 4;
  localparam int RULE_NUM  = PARSER_RULE_NUM;
  localparam int RW        = $bits(type_rule_t);

  logic                               i_clk = 1'b0;
  logic                               i_rst_n = 1'b0;
  logic                               i_cfg_valid = 1'b0;
  logic [31:0]                        i_cfg_data = '0;
  logic                               o_cfg_ready;
  logic [STAGE_NUM-1:0][RULE_NUM-1:0] o_rule_wren;
  type_rule_t                         o_type_rule;
  logic                               o_busy;
  logic                               o_cfg_err;
  logic [15:0]                        o_wr_cnt;

  type_rule_cfg_ctrl #(
    .STAGE_NUM (STAGE_NUM),
    .RULE_NUM  (RULE_NUM)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_data  (i_cfg_data),
    .o_rule_wren (o_rule_wren),
    .o_type_rule (o_type_rule),
    .o_busy      (o_busy),
    .o_cfg_err   (o_cfg_err),
    .o_wr_cnt    (o_wr_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string        name;
    logic [31:0]  wren;
    logic [RW-1:0] rule;
    logic         err;
    logic [15:0]  cnt;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            tests = 0;
  int            fails = 0;
  logic [RW-1:0] m_rule = '0;
  logic [15:0]   m_cnt  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [1:0] op, input int st, input int rl);
    return {op, 6'(st), 8'(rl), 16'h0000};
  endfunction

  function automatic logic [31:0] wbit(input int st, input int rl);
    return 32'd1 << (st * RULE_NUM + rl);
  endfunction

  // Push the event the DUT must present one cycle after the triggering word.
  task automatic expect_ev(input string name, input logic [31:0] wren, input logic err,
                           input logic upd, input logic [RW-1:0] rule, input logic inc);
    exp_t e;
    if (upd) m_rule = rule;
    if (inc) m_cnt  = m_cnt + 16'd1;
    e.name = name;
    e.wren = wren;
    e.rule = m_rule;
    e.err  = err;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  // Called just after a negedge; returns at the negedge following the transfer.
  task automatic send(input logic [31:0] w, input int gap);
    int n;
    if (gap > 0) begin
      i_cfg_valid = 1'b0;
      repeat (gap) @(negedge i_clk);
    end
    i_cfg_valid = 1'b1;
    i_cfg_data  = w;
    n = 0;
    while (!o_cfg_ready && n < 64) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 64) check("ready_timeout", 64'(o_cfg_ready), 64'd1);
    @(negedge i_clk);
    i_cfg_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(o_cfg_ready), 64'd1);
    check({tag, "_wren"},  64'(o_rule_wren), 64'd0);
    check({tag, "_rule"},  64'(o_type_rule), 64'd0);
    check({tag, "_busy"},  64'(o_busy),      64'd0);
    check({tag, "_err"},   64'(o_cfg_err),   64'd0);
    check({tag, "_cnt"},   64'(o_wr_cnt),    64'd0);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && ((|o_rule_wren) || o_cfg_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {31'd0, o_cfg_err, 32'(o_rule_wren)}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_wren"}, 64'(o_rule_wren), 64'(mon_e.wren));
        check({mon_e.name, "_rule"}, 64'(o_type_rule), 64'(mon_e.rule));
        check({mon_e.name, "_err"},  64'(o_cfg_err),   64'(mon_e.err));
        check({mon_e.name, "_cnt"},  64'(o_wr_cnt),    64'(mon_e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check_idle_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Stage 1 / rule 3, payload 0x1, 0x2 -> rule = {word1[16:0], word0}.
    send(hdr(2'b00, 1, 3), 0);
    check("w1_busy_in_load", 64'(o_busy), 64'd1);
    send(32'h0000_0001, 0);
    expect_ev("w1", wbit(1, 3), 1'b0, 1'b1, 49'h0_0002_0000_0001, 1'b1);
    send(32'h0000_0002, 0);
    check("w1_ready_low_commit", 64'(o_cfg_ready), 64'd0);
    @(negedge i_clk);
    check("w1_ready_back", 64'(o_cfg_ready), 64'd1);
    check("w1_idle_busy", 64'(o_busy), 64'd0);

    // Upper word bits past bit 48 are dropped; valid bit ends up set.
    send(hdr(2'b00, 2, 7), 0);
    send(32'hDEAD_BEEF, 0);
    expect_ev("w2", wbit(2, 7), 1'b0, 1'b1, 49'h1_FFFF_DEAD_BEEF, 1'b1);
    send(32'hFFFF_FFFF, 0);

    // Same rule as w1 but with valid gaps between words.
    send(hdr(2'b00, 1, 3), 2);
    send(32'h0000_0001, 5);
    expect_ev("w3_gaps", wbit(1, 3), 1'b0, 1'b1, 49'h0_0002_0000_0001, 1'b1);
    send(32'h0000_0002, 3);

    expect_ev("clear_all", 32'hFFFF_FFFF, 1'b0, 1'b1, '0, 1'b1);
    send(hdr(2'b10, 0, 0), 0);
    check("clr_all_ready_low", 64'(o_cfg_ready), 64'd0);

    // Some payload first so the clear visibly zeroes the rule.
    send(hdr(2'b00, 0, 6), 0);
    send(32'h1234_5678, 0);
    expect_ev("w4", wbit(0, 6), 1'b0, 1'b1, 49'h1_ABCD_1234_5678, 1'b1);
    send(32'h0001_ABCD, 0);

    expect_ev("clear_one", wbit(3, 5), 1'b0, 1'b1, '0, 1'b1);
    send(hdr(2'b01, 3, 5), 0);

    expect_ev("clear_one_bad", 32'd0, 1'b1, 1'b0, '0, 1'b0);
    send(hdr(2'b01, 0, RULE_NUM), 0);

    send(hdr(2'b00, 1, 1), 0);
    send(32'h0000_0011, 0);
    expect_ev("w5", wbit(1, 1), 1'b0, 1'b1, 49'h0_0022_0000_0011, 1'b1);
    send(32'h0000_0022, 0);

    // Out-of-range stage: both words consumed, error one cycle later, no wren.
    send(hdr(2'b00, STAGE_NUM, 0), 0);
    send(32'hAAAA_5555, 0);
    expect_ev("write_bad_stage", 32'd0, 1'b1, 1'b0, '0, 1'b0);
    send(32'h5555_AAAA, 0);
    check("bad_write_ready_low", 64'(o_cfg_ready), 64'd0);

    expect_ev("reserved_op", 32'd0, 1'b1, 1'b0, '0, 1'b0);
    send(32'hC000_0000, 0);
    check("reserved_busy", 64'(o_busy), 64'd0);
    check("reserved_ready", 64'(o_cfg_ready), 64'd1);

    // Reset after half the payload: partial rule must never be committed.
    send(hdr(2'b00, 2, 1), 0);
    send(32'h1111_1111, 0);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    check_idle_outputs("mid_load_reset");
    m_rule = '0;
    m_cnt  = '0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    send(hdr(2'b00, 0, 0), 0);
    send(32'hCAFE_F00D, 0);
    expect_ev("w_after_reset", wbit(0, 0), 1'b0, 1'b1, 49'h1_0000_CAFE_F00D, 1'b1);
    send(32'h0001_0000, 0);

    repeat (4) @(negedge i_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
